// File: rtl/multicycle_controller.sv
// multicycle_controller: main sequencing FSM for the multicycle RV32I datapath.
// Fetches, decodes and executes one instruction at a time through a fixed
// per-class state sequence. It is the only driver of the datapath selects and
// enables. Outputs are a Moore decode of the state, except that alu_control in
// EXECR/EXECI follows the funct fields and PC_write in BRANCH follows Zero.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    FETCH2   = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWAIT  = 4'd5,
    MEMWB    = 4'd6,
    MEMWRITE = 4'd7,
    EXECR    = 4'd8,
    EXECI    = 4'd9,
    ALUWB    = 4'd10,
    BRANCH   = 4'd11,
    JAL      = 4'd12,
    JALR     = 4'd13,
    JALR2    = 4'd14,
    UTYPE    = 4'd15
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operations (shared encoding with alu)
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Immediate formats (shared encoding with extend)
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  state_t state_q;
  state_t state_d;

  // Only funct7[5] selects SUB/SRA; the other bits are don't-care here.
  logic funct7_unused;
  assign funct7_unused = ^{funct7[6], funct7[4:0]};

  // funct3 -> ALU op for register and immediate arithmetic.
  function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                          input logic       sub_en,
                                          input logic       sra_en);
    logic [3:0] op;
    case (f3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: fixed sequence per instruction class.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:  state_d = FETCH2;
        FETCH2: state_d = DECODE;
        DECODE: begin
          case (op_code)
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_RTYPE:          state_d = EXECR;
            OP_ITYPE:          state_d = EXECI;
            OP_BRANCH:         state_d = BRANCH;
            OP_JAL:            state_d = JAL;
            OP_JALR:           state_d = JALR;
            OP_LUI, OP_AUIPC:  state_d = UTYPE;
            default:           state_d = FETCH;
          endcase
        end
        MEMADR: begin
          if (op_code == OP_STORE) begin
            state_d = MEMWRITE;
          end else begin
            state_d = MEMREAD;
          end
        end
        MEMREAD:  state_d = MEMWAIT;
        MEMWAIT:  state_d = MEMWB;
        MEMWB:    state_d = FETCH;
        MEMWRITE: state_d = FETCH;
        EXECR:    state_d = ALUWB;
        EXECI:    state_d = ALUWB;
        ALUWB:    state_d = FETCH;
        BRANCH:   state_d = FETCH;
        JAL:      state_d = ALUWB;
        JALR:     state_d = JALR2;
        JALR2:    state_d = ALUWB;
        UTYPE:    state_d = ALUWB;
        default:  state_d = FETCH;
      endcase
    end
  end

  // Output decode; everything is held at 0 while reset is high.
  always_comb begin
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    IR_write    = 1'b0;
    reg_write   = 1'b0;
    PC_write    = 1'b0;
    result_src  = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    illegal_op  = 1'b0;
    if (reset) begin
      adr_src = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          adr_src = 1'b0;
        end
        FETCH2: begin
          // PC <= PC + 4 while the IR and old_PC capture the fetch.
          IR_write   = 1'b1;
          PC_write   = 1'b1;
          alu_src_a  = 2'd0;
          alu_src_b  = 2'd2;
          result_src = 2'd2;
        end
        DECODE: begin
          // ALU_out <= old_PC + imm (branch / JAL target).
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          case (op_code)
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
          endcase
          case (op_code)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal_op = 1'b0;
            default:                           illegal_op = 1'b1;
          endcase
        end
        MEMADR, MEMREAD, MEMWAIT, MEMWRITE: begin
          // Address operands stay applied so ALU_out keeps the address.
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          if (op_code == OP_STORE) begin
            imm_src = IMM_S;
          end else begin
            imm_src = IMM_I;
          end
          if (state_q == MEMADR) begin
            adr_src = 1'b0;
          end else begin
            adr_src    = 1'b1;
            result_src = 2'd0;
          end
          if (state_q == MEMWRITE) begin
            mem_write = 1'b1;
          end else begin
            mem_write = 1'b0;
          end
        end
        MEMWB: begin
          result_src = 2'd1;
          reg_write  = 1'b1;
        end
        EXECR: begin
          alu_src_a   = 2'd2;
          alu_src_b   = 2'd0;
          alu_control = arith_op(funct3, funct7[5], funct7[5]);
        end
        EXECI: begin
          // Immediate forms have no SUB; funct7[5] only selects SRAI.
          alu_src_a   = 2'd2;
          alu_src_b   = 2'd1;
          imm_src     = IMM_I;
          alu_control = arith_op(funct3, 1'b0, funct7[5]);
        end
        ALUWB: begin
          result_src = 2'd0;
          reg_write  = 1'b1;
        end
        BRANCH: begin
          // Compare rs1/rs2; ALU_out already holds the target.
          alu_src_a  = 2'd2;
          alu_src_b  = 2'd0;
          result_src = 2'd0;
          case (funct3)
            3'b000: begin alu_control = ALU_SUB;  PC_write = Zero;  end
            3'b001: begin alu_control = ALU_SUB;  PC_write = ~Zero; end
            3'b100: begin alu_control = ALU_SLT;  PC_write = ~Zero; end
            3'b101: begin alu_control = ALU_SLT;  PC_write = Zero;  end
            3'b110: begin alu_control = ALU_SLTU; PC_write = ~Zero; end
            3'b111: begin alu_control = ALU_SLTU; PC_write = Zero;  end
            default: begin
              alu_control = ALU_ADD;
              PC_write    = 1'b0;
              illegal_op  = 1'b1;
            end
          endcase
        end
        JAL, JALR2: begin
          // PC <= ALU_out (target) while ALU_out becomes old_PC + 4.
          result_src = 2'd0;
          PC_write   = 1'b1;
          alu_src_a  = 2'd1;
          alu_src_b  = 2'd2;
        end
        JALR: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          imm_src   = IMM_I;
        end
        UTYPE: begin
          imm_src   = IMM_U;
          alu_src_b = 2'd1;
          if (op_code == OP_LUI) begin
            alu_control = ALU_PASSB;
          end else begin
            alu_src_a   = 2'd1;
            alu_control = ALU_ADD;
          end
        end
        default: begin
          adr_src = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Every cycle the driver applies
// the instruction fields and pushes the hand-computed control vector for that
// cycle; a monitor on the falling edge pops and compares it to the DUT.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3),
    .funct7(funct7), .Zero(Zero), .adr_src(adr_src), .mem_write(mem_write),
    .IR_write(IR_write), .reg_write(reg_write), .PC_write(PC_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [18:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Current instruction fields applied by the driver.
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;
  logic       cur_z;

  // Packs one expected control vector:
  // {adr, mem_write, IR_write, reg_write, PC_write, result_src, src_a, src_b, imm_src, alu, illegal}
  function automatic logic [18:0] pk(input logic adr, input logic mw, input logic irw,
                                     input logic rw, input logic pcw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic ill);
    return {adr, mw, irw, rw, pcw, rs, sa, sb, imm, alu, ill};
  endfunction

  task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic z);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
  endtask

  // One clock: drive inputs just after the rising edge and queue the expectation.
  task automatic cyc(input logic rst, input logic [18:0] e, input string tag);
    @(posedge clk);
    #1;
    reset   = rst;
    op_code = cur_op;
    funct3  = cur_f3;
    funct7  = cur_f7;
    Zero    = cur_z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Common fetch prologue.
  task automatic fetch_pair(input string name);
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,4'd0,0), {name, "_fetch"});
    cyc(1'b0, pk(0,0,1,0,1,2'd2,2'd0,2'd2,3'd0,4'd0,0), {name, "_fetch2"});
  endtask

  logic [18:0] act;
  logic [18:0] mon_e;
  string       mon_t;
  assign act = {adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_op};

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      n_checks++;
      if (act !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got %05h expected %05h", mon_t, act, mon_e);
      end
    end
  end

  logic [18:0] e_dec, e_aluwb;

  initial begin
    reset = 1'b1; op_code = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0;
    e_dec   = pk(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,4'd0,0);
    e_aluwb = pk(0,0,0,1,0,2'd0,2'd0,2'd0,3'd0,4'd0,0);

    // Reset for two cycles: all outputs low.
    ins(7'b0110011, 3'b000, 7'b0000000, 1'b0);
    cyc(1'b1, 19'd0, "reset0");
    cyc(1'b1, 19'd0, "reset1");

    // add x3,x1,x2
    fetch_pair("add");
    cyc(1'b0, e_dec, "add_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,4'd0,0), "add_execr");
    cyc(1'b0, e_aluwb, "add_aluwb");

    // sub (funct7[5]=1)
    ins(7'b0110011, 3'b000, 7'b0100000, 1'b1);
    fetch_pair("sub");
    cyc(1'b0, e_dec, "sub_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,4'd1,0), "sub_execr");
    cyc(1'b0, e_aluwb, "sub_aluwb");

    // lw x4,8(x0)
    ins(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    fetch_pair("lw");
    cyc(1'b0, e_dec, "lw_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,4'd0,0), "lw_memadr");
    cyc(1'b0, pk(1,0,0,0,0,2'd0,2'd2,2'd1,3'd0,4'd0,0), "lw_memread");
    cyc(1'b0, pk(1,0,0,0,0,2'd0,2'd2,2'd1,3'd0,4'd0,0), "lw_memwait");
    cyc(1'b0, pk(0,0,0,1,0,2'd1,2'd0,2'd0,3'd0,4'd0,0), "lw_memwb");

    // beq, equal operands: taken
    ins(7'b1100011, 3'b000, 7'b0000000, 1'b1);
    fetch_pair("beq");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd1,2'd1,3'd2,4'd0,0), "beq_decode");
    cyc(1'b0, pk(0,0,0,0,1,2'd0,2'd2,2'd0,3'd0,4'd1,0), "beq_branch");

    // bge rs1=-1, rs2=0: SLT gives 1, Zero=0, not taken
    ins(7'b1100011, 3'b101, 7'b0000000, 1'b0);
    fetch_pair("bge");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd1,2'd1,3'd2,4'd0,0), "bge_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,4'd5,0), "bge_branch");

    // bltu with Zero=0: taken
    ins(7'b1100011, 3'b110, 7'b0000000, 1'b0);
    fetch_pair("bltu");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd1,2'd1,3'd2,4'd0,0), "bltu_decode");
    cyc(1'b0, pk(0,0,0,0,1,2'd0,2'd2,2'd0,3'd0,4'd6,0), "bltu_branch");

    // Branch funct3=010 is illegal: pulse, no PC write even with Zero=1
    ins(7'b1100011, 3'b010, 7'b0000000, 1'b1);
    fetch_pair("bill");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd1,2'd1,3'd2,4'd0,0), "bill_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,4'd0,1), "bill_branch");

    // jalr x1,4(x5): 6 cycles
    ins(7'b1100111, 3'b000, 7'b0000000, 1'b0);
    fetch_pair("jalr");
    cyc(1'b0, e_dec, "jalr_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,4'd0,0), "jalr_jalr");
    cyc(1'b0, pk(0,0,0,0,1,2'd0,2'd1,2'd2,3'd0,4'd0,0), "jalr_jalr2");
    cyc(1'b0, e_aluwb, "jalr_aluwb");

    // jal
    ins(7'b1101111, 3'b000, 7'b0000000, 1'b0);
    fetch_pair("jal");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd1,2'd1,3'd3,4'd0,0), "jal_decode");
    cyc(1'b0, pk(0,0,0,0,1,2'd0,2'd1,2'd2,3'd0,4'd0,0), "jal_jal");
    cyc(1'b0, e_aluwb, "jal_aluwb");

    // addi with funct7[5]=1 in the immediate: still ADD
    ins(7'b0010011, 3'b000, 7'b0100000, 1'b0);
    fetch_pair("addi");
    cyc(1'b0, e_dec, "addi_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,4'd0,0), "addi_execi");
    cyc(1'b0, e_aluwb, "addi_aluwb");

    // srai: funct7[5] honoured for funct3=101
    ins(7'b0010011, 3'b101, 7'b0100000, 1'b0);
    fetch_pair("srai");
    cyc(1'b0, e_dec, "srai_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,4'd9,0), "srai_execi");
    cyc(1'b0, e_aluwb, "srai_aluwb");

    // lui
    ins(7'b0110111, 3'b000, 7'b0000000, 1'b0);
    fetch_pair("lui");
    cyc(1'b0, e_dec, "lui_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd0,2'd1,3'd4,4'd10,0), "lui_utype");
    cyc(1'b0, e_aluwb, "lui_aluwb");

    // auipc
    ins(7'b0010111, 3'b000, 7'b0000000, 1'b0);
    fetch_pair("auipc");
    cyc(1'b0, e_dec, "auipc_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd1,2'd1,3'd4,4'd0,0), "auipc_utype");
    cyc(1'b0, e_aluwb, "auipc_aluwb");

    // Illegal opcode 0x7F: pulse in DECODE, then straight back to FETCH
    ins(7'h7F, 3'b000, 7'b0000000, 1'b0);
    fetch_pair("ill");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,4'd0,1), "ill_decode");

    // sw completes normally
    ins(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    fetch_pair("sw");
    cyc(1'b0, e_dec, "sw_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd1,3'd1,4'd0,0), "sw_memadr");
    cyc(1'b0, pk(1,1,0,0,0,2'd0,2'd2,2'd1,3'd1,4'd0,0), "sw_memwrite");

    // sw aborted by reset in its MEMWRITE cycle: no write strobe
    fetch_pair("swr");
    cyc(1'b0, e_dec, "swr_decode");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd2,2'd1,3'd1,4'd0,0), "swr_memadr");
    cyc(1'b1, 19'd0, "swr_reset");
    cyc(1'b0, pk(0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,4'd0,0), "swr_refetch");
    cyc(1'b0, pk(0,0,1,0,1,2'd2,2'd0,2'd2,3'd0,4'd0,0), "swr_refetch2");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing FSM for the multicycle RV32I datapath. Each cycle it decodes `op_code`, `funct3`, `funct7` and `Zero` from the datapath and drives every datapath select and enable. It fetches, decodes and executes one instruction at a time through a fixed per-class state sequence. It sits beside the datapath in the CPU top and is the only driver of the datapath control inputs.

## Interface
- No parameters. All encodings below are fixed and shared with `alu`, `extend` and the datapath muxes.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset
- `op_code`  in  7  IR[6:0]
- `funct3`  in  3  IR[14:12]
- `funct7`  in  7  IR[31:25]; only bit 5 is used
- `Zero`  in  1  ALU result == 0 (combinational, current cycle)
- `adr_src`  out  1  memory address select: 0 = PC, 1 = result
- `mem_write`  out  1  data memory write strobe
- `IR_write`  out  1  loads the IR and the old-PC register
- `reg_write`  out  1  register file write
- `PC_write`  out  1  PC load enable
- `result_src`  out  2  result select: 0 = ALU_out, 1 = dmem_data, 2 = ALU_result
- `alu_src_a`  out  2  SrcA select: 0 = PC, 1 = old_PC, 2 = rs1 flop
- `alu_src_b`  out  2  SrcB select: 0 = rs2 flop, 1 = immediate, 2 = constant 4
- `imm_src`  out  3  immediate format: 0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- `alu_control`  out  4  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode is unsupported

## Operation
- State register is updated on `posedge clk`. While `reset` is high, the next state is FETCH.
- While `reset` is high, all outputs are forced to 0.
- Outputs are a Moore decode of the state, with two exceptions:
  - `alu_control` in EXECR/EXECI is decoded from the funct fields.
  - `PC_write` in BRANCH depends on `Zero`.
- Unlisted outputs are 0 in every state.
- Per-state outputs and transitions:
  - FETCH: adr_src=0. Next: FETCH2. Gives the synchronous imem one cycle to return the instruction.
  - FETCH2: adr_src=0, IR_write=1, src_a=0, src_b=2, ADD, result_src=2, PC_write=1. PC becomes PC+4; old_PC captures the pre-increment PC. Next: DECODE.
  - DECODE: src_a=1, imm_src=B for branches and J for JAL, src_b=1, ADD. ALU_out receives the branch/JAL target; the rs1/rs2 flops load.
    - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111/0010111 → UTYPE.
    - Any other opcode: `illegal_op`=1, next FETCH.
  - MEMADR: src_a=2, src_b=1, imm_src = S for stores and I for loads, ADD. Next: MEMWRITE for stores, MEMREAD for loads.
  - MEMREAD and MEMWAIT: adr_src=1, result_src=0. The ALU operands of MEMADR are held so that ALU_out keeps the address. MEMREAD → MEMWAIT → MEMWB.
  - MEMWB: result_src=1, reg_write=1. Next: FETCH.
  - MEMWRITE: operands of MEMADR held, adr_src=1, result_src=0, mem_write=1. Next: FETCH.
  - EXECR: src_a=2, src_b=0. ALU op from funct3: 000 ADD/SUB (SUB if funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA if funct7[5]), 110 OR, 111 AND. Next: ALUWB.
  - EXECI: src_a=2, src_b=1, imm_src=I, same funct3 map, except funct7[5] is honoured only for funct3=101. Next: ALUWB.
  - ALUWB: result_src=0, reg_write=1. Next: FETCH.
  - BRANCH: src_a=2, src_b=0, result_src=0 (target).
    - ALU op: beq/bne SUB; blt/bge SLT; bltu/bgeu SLTU.
    - Taken condition: beq Zero; bne !Zero; blt/bltu !Zero; bge/bgeu Zero.
    - PC_write = taken. Next: FETCH.
  - JAL: result_src=0, PC_write=1; src_a=1, src_b=2, ADD, so ALU_out becomes old_PC+4. Next: ALUWB.
  - JALR: src_a=2, src_b=1, imm_src=I, ADD. Next: JALR2.
  - JALR2: result_src=0, PC_write=1; src_a=1, src_b=2, ADD. Next: ALUWB.
  - UTYPE: imm_src=U, src_b=1. LUI: PASS_B. AUIPC: src_a=1, ADD. Next: ALUWB.
- Branch funct3 values 010 and 011 are illegal: `illegal_op` pulses in BRANCH, PC_write=0.

## Timing
- Cycles per instruction, FETCH to FETCH: branch 4; R/I/store/JAL/LUI/AUIPC 5; JALR 6; load 7.
- First FETCH is the cycle after `reset` deasserts. PC holds 0x1000 from the datapath reset.
- Reset asserted in any state aborts the instruction that edge. A write strobe is never issued in the reset cycle.
- `PC_write` and `reg_write` are never both high in the same cycle.
- `IR_write` is high only in FETCH2.

## Test plan
- Reset for 2 cycles, release → FETCH, FETCH2 (IR_write=1, PC_write=1), and the PC reads 0x1004 after FETCH2.
- `add x3,x1,x2` with x1=5, x2=7 → reaches ALUWB on cycle 5 with reg_write=1 and x3=12; repeat with funct7[5]=1 (`sub`) and check x3=-2 (0xFFFFFFFE).
- `lw x4,8(x0)` with mem[8]=0xDEADBEEF → MEMREAD/MEMWAIT hold adr_src=1; MEMWB writes x4=0xDEADBEEF on cycle 7.
- `beq` with equal operands → PC_write=1 in BRANCH and PC = old_PC+imm. `bge` with rs1=-1, rs2=0 (SLT → 1, Zero=0) → PC_write=0.
- `jalr x1,4(x5)` with x5=0x2000 at PC 0x1010 → PC=0x2004 and x1=0x1014, 6 cycles.
- Opcode 0x7F → illegal_op pulses in DECODE, no writes, next state FETCH. Assert reset mid-MEMWRITE sequence → mem_write stays 0.
